viterbi_step_ctrl: RTL and testbench
====================================

Name: viterbi_step_ctrl

Overview:
- Sequencer that runs a full Viterbi decode over an observation sequence using one shared column datapath.
- The datapath computes one state column j per invocation: it takes start, all δ[n-1,·] and logA[·][j], and returns δ[n,j], ψ[n,j] and a done pulse.
- Per time step, the controller fetches the observation, issues columns 0..I-1, writes δ into a ping-pong bank and ψ into the traceback memory, then swaps banks.
- On the final step it tracks the best final state.

Parameters:
- I, 8, number of HMM states; must be a power of two, ≥2.
- FW, 16, fixed-point width of log-probabilities; signed two's complement.
- NMAX, 64, maximum observation length.
- OW, 4, observation symbol width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse; begin a decode; ignored unless idle.
- num_obs  in  $clog2(NMAX)+1  sequence length N; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start through the FINISH state.
- done  out  1  one-cycle pulse at end of decode.
- err  out  1  sticky until next accepted start; set when N==0 or N>NMAX.
- obs_addr  out  $clog2(NMAX)  observation memory address (= n).
- obs_data  in  OW  observation symbol; 1-cycle read latency.
- obs_q  out  OW  registered current symbol; drives the external logB ROM address.
- col_idx  out  $clog2(I)  current column j; drives the logA, logB and logpi ROM addresses.
- logpi_in  in  FW  logπ[col_idx]; combinational ROM.
- logB_in  in  FW  logB[col_idx][obs_q]; combinational ROM.
- chain_start  out  1  one-cycle pulse to the datapath.
- chain_done  in  1  datapath result-valid pulse.
- chain_delta  in  FW  δ[n,j] from the datapath.
- chain_psi  in  $clog2(I)  ψ[n,j] from the datapath.
- rd_bank  out  1  δ bank feeding the datapath δ[n-1,·]; always ~wr_bank.
- wr_bank  out  1  δ bank being written.
- delta_we  out  1  δ write strobe.
- delta_waddr  out  $clog2(I)  δ write address (= j).
- delta_wdata  out  FW  δ write data.
- psi_we  out  1  ψ write strobe.
- psi_waddr  out  $clog2(NMAX)+$clog2(I)  ψ write address, {n, j}.
- psi_wdata  out  $clog2(I)  ψ write data.
- best_state  out  $clog2(I)  argmax_j δ[N-1,j]; valid from the done pulse until the next accepted start.
- best_delta  out  FW  max_j δ[N-1,j]; same validity as best_state.

Behaviour:
- Reset, synchronous, also mid-operation:
  - state = IDLE.
  - All strobes, busy, done and err are 0.
  - wr_bank = 0; n, j, obs_q, best_state and best_delta are 0.
  - Any in-flight datapath result is discarded.
- Counters:
  - n counts 0..N-1.
  - j counts 0..I-1 and wraps to 0 at the end of each step.
- States:
  - IDLE: on start with 1≤N≤NMAX, latch N, clear err, clear the best tracker, n=0, j=0, go to FETCH. Bad N: set err, pulse done the next cycle, return to IDLE.
  - FETCH (1 cycle): drive obs_addr=n. Next cycle obs_q<=obs_data. Go to INIT if n==0, else ISSUE.
  - INIT (I cycles, one per j): delta_we=1, delta_wdata = logpi_in+logB_in (FW-bit wrap), no ψ write. After j=I-1 go to SWAP.
  - ISSUE (1 cycle): chain_start=1. Go to WAIT.
  - WAIT: hold col_idx, obs_q and banks stable. On chain_done go to WRITE. chain_done seen in any other state is ignored.
  - WRITE (1 cycle):
    - δ write: delta_we=1, delta_wdata=chain_delta.
    - ψ write: psi_we=1, psi_waddr={n,j}, psi_wdata=chain_psi.
    - If j<I-1: j++, go to ISSUE. Else go to SWAP.
  - SWAP (1 cycle): toggle wr_bank, j=0. If n==N-1 go to FINISH. Else n++, go to FETCH.
  - FINISH (1 cycle): done=1, busy=0 next, return to IDLE.
- Best tracker:
  - Updates on every δ write while n==N-1 (INIT when N==1, WRITE otherwise).
  - Signed compare, strict greater-than, so ties keep the lower j.
  - The first write of the step loads unconditionally.
- Arithmetic: all adds are FW-bit signed with wrap, no saturation.
- Handshake and latency:
  - start while busy is ignored.
  - Step n≥1 costs 2 + I·(L+2) cycles, where L is the datapath latency from chain_start to chain_done.
  - Step 0 costs I+2 cycles.

Decomposition:
- Package viterbi_pkg holds:
  - the state enum (IDLE, FETCH, INIT, ISSUE, WAIT, WRITE, SWAP, FINISH);
  - localparams SW=$clog2(I) and NW=$clog2(NMAX);
  - the default FW.
- One natural sub-module: viterbi_argmax_tracker, a clear/load/update signed running max with index. The decode top instantiates it alongside the datapath.

Test Plan:
- N=1, I=8, logpi=j, logB=10 → 8 δ writes with data 10..17; no ψ writes; best_state=7, best_delta=17; done at cycle 11 after start.
- N=3 with a mock datapath (L=8, chain_delta=100+j, chain_psi=j^1) → 16 ψ writes at addresses {1,0}..{2,7}; wr_bank toggles 3 times; best_state=7.
- Tie: final δ all equal to -5 → best_state=0, best_delta=-5 (0xFFFB).
- Wrap: logpi=0x7FFF, logB=0x0001 → delta_wdata=0x8000.
- N=0 or N=65 → err=1, done one cycle later, no writes; a start pulsed while busy during a decode has no effect.
- rst_n low mid-WAIT → next cycle IDLE, wr_bank=0, busy=0; a late chain_done produces no write; a restart decodes correctly.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and default sizes for the Viterbi step controller.
package viterbi_pkg;

  localparam int unsigned NumStates = 8;
  localparam int unsigned MaxObs    = 64;
  localparam int unsigned FwDefault = 16;
  localparam int unsigned ObsWidth  = 4;
  localparam int unsigned SW        = $clog2(NumStates);
  localparam int unsigned NW        = $clog2(MaxObs);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StInit,
    StIssue,
    StWait,
    StWrite,
    StSwap,
    StFinish
  } state_e;

endpackage

// File: rtl/viterbi_step_ctrl_if.sv
// Bundle of control, memory and datapath signals around the Viterbi step controller.
interface viterbi_step_ctrl_if
  import viterbi_pkg::*;
#(
  parameter int unsigned I    = NumStates,
  parameter int unsigned FW   = FwDefault,
  parameter int unsigned NMAX = MaxObs,
  parameter int unsigned OW   = ObsWidth
);
  localparam int unsigned Sw = $clog2(I);
  localparam int unsigned Nw = $clog2(NMAX);

  logic             start;
  logic [Nw:0]      num_obs;
  logic             busy;
  logic             done;
  logic             err;
  logic [Nw-1:0]    obs_addr;
  logic [OW-1:0]    obs_data;
  logic [OW-1:0]    obs_q;
  logic [Sw-1:0]    col_idx;
  logic [FW-1:0]    logpi_in;
  logic [FW-1:0]    logB_in;
  logic             chain_start;
  logic             chain_done;
  logic [FW-1:0]    chain_delta;
  logic [Sw-1:0]    chain_psi;
  logic             rd_bank;
  logic             wr_bank;
  logic             delta_we;
  logic [Sw-1:0]    delta_waddr;
  logic [FW-1:0]    delta_wdata;
  logic             psi_we;
  logic [Nw+Sw-1:0] psi_waddr;
  logic [Sw-1:0]    psi_wdata;
  logic [Sw-1:0]    best_state;
  logic [FW-1:0]    best_delta;

  modport master (
    input  start, num_obs, obs_data, logpi_in, logB_in, chain_done, chain_delta, chain_psi,
    output busy, done, err, obs_addr, obs_q, col_idx, chain_start, rd_bank, wr_bank,
           delta_we, delta_waddr, delta_wdata, psi_we, psi_waddr, psi_wdata,
           best_state, best_delta
  );

  modport slave (
    output start, num_obs, obs_data, logpi_in, logB_in, chain_done, chain_delta, chain_psi,
    input  busy, done, err, obs_addr, obs_q, col_idx, chain_start, rd_bank, wr_bank,
           delta_we, delta_waddr, delta_wdata, psi_we, psi_waddr, psi_wdata,
           best_state, best_delta
  );

endinterface

// File: rtl/viterbi_argmax_tracker.sv
// Signed running maximum with index; strict compare so ties keep the earliest index.
module viterbi_argmax_tracker
  import viterbi_pkg::*;
#(
  parameter int unsigned Width    = FwDefault,
  parameter int unsigned IdxWidth = SW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       upd_i,
  input  logic                       load_i,
  input  logic        [IdxWidth-1:0] idx_i,
  input  logic signed [Width-1:0]    val_i,
  output logic        [IdxWidth-1:0] idx_o,
  output logic signed [Width-1:0]    val_o
);

  logic        [IdxWidth-1:0] idx_q, idx_d;
  logic signed [Width-1:0]    val_q, val_d;

  always_comb begin
    idx_d = idx_q;
    val_d = val_q;
    if (clr_i) begin
      idx_d = '0;
      val_d = '0;
    end else if (upd_i && (load_i || (val_i > val_q))) begin
      idx_d = idx_i;
      val_d = val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      val_q <= '0;
    end else begin
      idx_q <= idx_d;
      val_q <= val_d;
    end
  end

  assign idx_o = idx_q;
  assign val_o = val_q;

endmodule

// File: rtl/viterbi_step_ctrl.sv
// Sequences a full Viterbi decode: per step, fetch the symbol, run every column through the
// shared datapath, store delta/psi, swap delta banks; tracks the best final state.
module viterbi_step_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned I    = NumStates,
  parameter int unsigned FW   = FwDefault,
  parameter int unsigned NMAX = MaxObs,
  parameter int unsigned OW   = ObsWidth
) (
  input logic                 clk,
  input logic                 rst_n,
  viterbi_step_ctrl_if.master bus
);

  localparam int unsigned   Sw        = $clog2(I);
  localparam int unsigned   Nw        = $clog2(NMAX);
  localparam logic [Sw-1:0] JLast     = Sw'(I - 1);
  localparam logic [Nw:0]   NumObsMax = (Nw + 1)'(NMAX);

  state_e        state_q, state_d;
  logic [Nw-1:0] n_q, n_d;
  logic [Nw-1:0] nlast_q, nlast_d;
  logic [Sw-1:0] j_q, j_d;
  logic [OW-1:0] obs_q, obs_d;
  logic          wr_bank_q, wr_bank_d;
  logic          err_q, err_d;
  logic          bad_q, bad_d;

  logic          num_ok;
  logic          delta_we, psi_we, chain_start;
  logic          trk_clr, trk_upd;
  logic [FW-1:0] init_sum, delta_wdata;

  assign num_ok      = (bus.num_obs != '0) && (bus.num_obs <= NumObsMax);
  assign init_sum    = bus.logpi_in + bus.logB_in;
  assign delta_wdata = (state_q == StInit) ? init_sum : bus.chain_delta;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    nlast_d     = nlast_q;
    j_d         = j_q;
    obs_d       = obs_q;
    wr_bank_d   = wr_bank_q;
    err_d       = err_q;
    bad_d       = 1'b0;
    delta_we    = 1'b0;
    psi_we      = 1'b0;
    chain_start = 1'b0;
    trk_clr     = 1'b0;
    trk_upd     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (num_ok) begin
            nlast_d = Nw'(bus.num_obs - 1'b1);
            err_d   = 1'b0;
            trk_clr = 1'b1;
            n_d     = '0;
            j_d     = '0;
            state_d = StFetch;
          end else begin
            err_d = 1'b1;
            bad_d = 1'b1;
          end
        end
      end
      StFetch: begin
        obs_d   = bus.obs_data;
        state_d = (n_q == '0) ? StInit : StIssue;
      end
      StInit: begin
        delta_we = 1'b1;
        trk_upd  = (n_q == nlast_q);
        j_d      = j_q + 1'b1;
        if (j_q == JLast) state_d = StSwap;
      end
      StIssue: begin
        chain_start = 1'b1;
        state_d     = StWait;
      end
      StWait: begin
        if (bus.chain_done) state_d = StWrite;
      end
      StWrite: begin
        delta_we = 1'b1;
        psi_we   = 1'b1;
        trk_upd  = (n_q == nlast_q);
        if (j_q == JLast) begin
          state_d = StSwap;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = StIssue;
        end
      end
      StSwap: begin
        wr_bank_d = ~wr_bank_q;
        j_d       = '0;
        if (n_q == nlast_q) begin
          state_d = StFinish;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = StFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      n_q       <= '0;
      nlast_q   <= '0;
      j_q       <= '0;
      obs_q     <= '0;
      wr_bank_q <= 1'b0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      nlast_q   <= nlast_d;
      j_q       <= j_d;
      obs_q     <= obs_d;
      wr_bank_q <= wr_bank_d;
      err_q     <= err_d;
      bad_q     <= bad_d;
    end
  end

  viterbi_argmax_tracker #(
    .Width    (FW),
    .IdxWidth (Sw)
  ) u_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (trk_clr),
    .upd_i  (trk_upd),
    .load_i (j_q == '0),
    .idx_i  (j_q),
    .val_i  (delta_wdata),
    .idx_o  (bus.best_state),
    .val_o  (bus.best_delta)
  );

  // Address leads by one cycle so the registered memory has the symbol ready during FETCH.
  assign bus.obs_addr    = n_d;
  assign bus.obs_q       = obs_q;
  assign bus.col_idx     = j_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StFinish) || bad_q;
  assign bus.err         = err_q;
  assign bus.chain_start = chain_start;
  assign bus.rd_bank     = ~wr_bank_q;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.delta_we    = delta_we;
  assign bus.delta_waddr = j_q;
  assign bus.delta_wdata = delta_wdata;
  assign bus.psi_we      = psi_we;
  assign bus.psi_waddr   = {n_q, j_q};
  assign bus.psi_wdata   = bus.chain_psi;

endmodule

// File: tb/tb_viterbi_step_ctrl.sv
// Bench for viterbi_step_ctrl: vector table of whole decodes, write scoreboard, reset corner case.
module tb_viterbi_step_ctrl;

  localparam int unsigned I    = 8;
  localparam int unsigned FW   = 16;
  localparam int unsigned NMAX = 64;
  localparam int unsigned OW   = 4;
  localparam int unsigned SW   = 3;
  localparam int unsigned NW   = 6;
  localparam logic [SW-1:0] One = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  viterbi_step_ctrl_if #(.I(I), .FW(FW), .NMAX(NMAX), .OW(OW)) bus ();

  viterbi_step_ctrl #(.I(I), .FW(FW), .NMAX(NMAX), .OW(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [OW-1:0] obs_fn(input int n);
    return OW'((n + 5) & 15);
  endfunction

  function automatic logic [FW-1:0] pi_fn(input int mode, input int j);
    case (mode)
      0:       return FW'(j);
      1:       return 16'h7FFF;
      default: return FW'(-4 * j);
    endcase
  endfunction

  function automatic logic [FW-1:0] b_fn(input int mode, input int sym);
    case (mode)
      0:       return 16'd10;
      1:       return 16'd1;
      default: return FW'(3 * sym);
    endcase
  endfunction

  function automatic logic [FW-1:0] dp_fn(input int mode, input int j);
    case (mode)
      0:       return FW'(100 + j);
      1:       return 16'hFFFB;
      default: return (j == 2 || j == 5) ? 16'd300 : FW'(-1000 + j);
    endcase
  endfunction

  // Environment: start driver, registered observation memory, ROMs, mock datapath.
  logic          start_r = 1'b0;
  logic [NW:0]   nobs_r  = '0;
  logic [OW-1:0] obs_rd  = '0;
  int            pi_mode = 0;
  int            dp_mode = 0;
  int            dp_lat  = 8;
  int            dp_cnt  = 0;
  logic [SW-1:0] dp_j    = '0;
  logic          dp_done = 1'b0;
  logic [FW-1:0] dp_delta = '0;
  logic [SW-1:0] dp_psi  = '0;

  assign bus.start       = start_r;
  assign bus.num_obs     = nobs_r;
  assign bus.obs_data    = obs_rd;
  assign bus.logpi_in    = pi_fn(pi_mode, int'(bus.col_idx));
  assign bus.logB_in     = b_fn(pi_mode, int'(bus.obs_q));
  assign bus.chain_done  = dp_done;
  assign bus.chain_delta = dp_delta;
  assign bus.chain_psi   = dp_psi;

  always @(posedge clk) obs_rd <= obs_fn(int'(bus.obs_addr));

  always @(posedge clk) begin
    dp_done <= 1'b0;
    if (dp_cnt > 0) begin
      dp_cnt <= dp_cnt - 1;
      if (dp_cnt == 1) begin
        dp_done  <= 1'b1;
        dp_delta <= dp_fn(dp_mode, int'(dp_j));
        dp_psi   <= dp_j ^ One;
      end
    end
    if (bus.chain_start) begin
      if (dp_lat <= 1) begin
        dp_done  <= 1'b1;
        dp_delta <= dp_fn(dp_mode, int'(bus.col_idx));
        dp_psi   <= bus.col_idx ^ One;
      end else begin
        dp_cnt <= dp_lat - 1;
        dp_j   <= bus.col_idx;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic [SW-1:0] addr;
    logic [FW-1:0] data;
    logic          bank;
  } dexp_t;

  typedef struct {
    logic [NW+SW-1:0] addr;
    logic [SW-1:0]    data;
  } pexp_t;

  typedef struct {
    int            n;
    int            pi_mode;
    int            dp_mode;
    int            lat;
    bit            poke;
    bit            exp_err;
    int            exp_lat;
    int            exp_bs;
    logic [FW-1:0] exp_bd;
  } vec_t;

  dexp_t exp_d[$];
  pexp_t exp_p[$];
  dexp_t de_m;
  pexp_t pe_m;
  logic  nb_m;
  logic  bank = 1'b0;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  vec_t  vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Advance one cycle and score any writes seen at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.delta_we) begin
      if (exp_d.size() == 0) begin
        chk("delta_unexpected", 32'(bus.delta_waddr), 32'hFFFF_FFFF);
      end else begin
        de_m = exp_d.pop_front();
        nb_m = ~de_m.bank;
        chk("delta_addr", 32'(bus.delta_waddr), 32'(de_m.addr));
        chk("delta_data", 32'(bus.delta_wdata), 32'(de_m.data));
        chk("delta_bank", 32'(bus.wr_bank), 32'(de_m.bank));
        chk("rd_bank", 32'(bus.rd_bank), 32'(nb_m));
      end
    end
    if (bus.psi_we) begin
      if (exp_p.size() == 0) begin
        chk("psi_unexpected", 32'(bus.psi_waddr), 32'hFFFF_FFFF);
      end else begin
        pe_m = exp_p.pop_front();
        chk("psi_addr", 32'(bus.psi_waddr), 32'(pe_m.addr));
        chk("psi_data", 32'(bus.psi_wdata), 32'(pe_m.data));
        chk("obs_q", 32'(bus.obs_q), 32'(obs_fn(int'(bus.psi_waddr[NW+SW-1:SW]))));
      end
    end
  endtask

  task automatic push_expected(input int n_steps, input int pm, input int dm);
    dexp_t de;
    pexp_t pe;
    for (int s = 0; s < n_steps; s++) begin
      for (int j = 0; j < int'(I); j++) begin
        de.addr = SW'(j);
        de.bank = bank;
        de.data = (s == 0) ? pi_fn(pm, j) + b_fn(pm, int'(obs_fn(0))) : dp_fn(dm, j);
        exp_d.push_back(de);
        if (s > 0) begin
          pe.addr = (NW + SW)'(s * int'(I) + j);
          pe.data = SW'(j ^ 1);
          exp_p.push_back(pe);
        end
      end
      bank = ~bank;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    bit got;
    pi_mode = v.pi_mode;
    dp_mode = v.dp_mode;
    dp_lat  = v.lat;
    if (!v.exp_err) push_expected(v.n, v.pi_mode, v.dp_mode);
    start_r = 1'b1;
    nobs_r  = (NW + 1)'(v.n);
    t0      = cyc;
    got     = 1'b0;
    for (int k = 0; k < 5000 && !got; k++) begin
      tick();
      start_r = 1'b0;
      if (v.poke && k == 6) begin
        start_r = 1'b1;
        nobs_r  = '0;
      end
      if (bus.done) got = 1'b1;
    end
    start_r = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("done_latency", 32'(cyc - t0), 32'(v.exp_lat));
      chk("err_at_done", 32'(bus.err), 32'(v.exp_err));
      chk("busy_at_done", 32'(bus.busy), 32'(!v.exp_err));
      if (!v.exp_err) begin
        chk("best_state", 32'(bus.best_state), 32'(v.exp_bs));
        chk("best_delta", 32'(bus.best_delta), 32'(v.exp_bd));
      end
    end
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("err_sticky", 32'(bus.err), 32'(v.exp_err));
    chk("pending_delta", 32'(exp_d.size()), 32'd0);
    chk("pending_psi", 32'(exp_p.size()), 32'd0);
    chk("wr_bank_end", 32'(bus.wr_bank), 32'(bank));
    exp_d.delete();
    exp_p.delete();
  endtask

  initial begin
    bit seen;
    vecs[0] = '{1,  0, 0, 8, 1'b0, 1'b0, 11,   7, 16'd17};
    vecs[1] = '{0,  0, 0, 8, 1'b0, 1'b1, 1,    0, 16'd0};
    vecs[2] = '{3,  0, 0, 8, 1'b0, 1'b0, 175,  7, 16'd107};
    vecs[3] = '{2,  0, 1, 4, 1'b1, 1'b0, 61,   0, 16'hFFFB};
    vecs[4] = '{1,  1, 0, 8, 1'b0, 1'b0, 11,   0, 16'h8000};
    vecs[5] = '{65, 0, 0, 8, 1'b0, 1'b1, 1,    0, 16'd0};
    vecs[6] = '{64, 2, 2, 1, 1'b0, 1'b0, 1649, 2, 16'd300};

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_wr_bank", 32'(bus.wr_bank), 32'd0);
    chk("rst_rd_bank", 32'(bus.rd_bank), 32'd1);
    chk("rst_strobes", 32'({bus.delta_we, bus.psi_we, bus.chain_start}), 32'd0);
    chk("rst_best", 32'({bus.best_state, bus.best_delta}), 32'd0);
    chk("rst_obs_col", 32'({bus.obs_q, bus.col_idx}), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the datapath is busy; its late result must not be written.
    pi_mode = 0;
    dp_mode = 0;
    dp_lat  = 8;
    push_expected(1, 0, 0);
    start_r = 1'b1;
    nobs_r  = 7'd2;
    tick();
    start_r = 1'b0;
    seen    = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (bus.chain_start) seen = 1'b1;
    end
    chk("issue_seen", 32'(seen), 32'd1);
    tick();
    tick();
    chk("busy_in_wait", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bank  = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_wr_bank", 32'(bus.wr_bank), 32'd0);
    chk("midrst_rd_bank", 32'(bus.rd_bank), 32'd1);
    chk("midrst_col", 32'(bus.col_idx), 32'd0);
    chk("midrst_pending", 32'(exp_d.size()), 32'd0);
    repeat (12) tick();
    chk("midrst_idle", 32'(bus.busy), 32'd0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
